aes_multiblock_ctrl: RTL and testbench
======================================

// Module: aes_multiblock_ctrl
// PURPOSE
//  Parametrised control FSM for the AES HWPE: encrypts a run of NB_BLOCKS 128-bit blocks per job.
//  Per block it requests the plaintext source, runs the engine, then requests the ciphertext sink.
//  Block addresses advance by BLOCK_BYTES. A watchdog flags a stalled engine.
//  Sits between the slave register file and the streamer/engine, in place of the single-block FSM.
// PARAMETERS
//  ADDR_W       32   byte-address width of source/sink base addresses
//  CNT_W        16   width of block count; max job = 2**CNT_W-1 blocks
//  BLOCK_BYTES  16   address increment per block
//  WDOG_W       8    watchdog counter width; timeout = 2**WDOG_W-1 cycles in WAIT_ENG
// PORTS
//  clk               in   1       clock
//  reset             in   1       async active-high reset
//  clear             in   1       sync soft clear: same effect as reset, applied on the next edge
//  start_i           in   1       job start pulse from slave (honoured in IDLE only)
//  nb_blocks_i       in   CNT_W   blocks in job, sampled on start
//  src_base_i        in   ADDR_W  plaintext base address, sampled on start
//  dst_base_i        in   ADDR_W  ciphertext base address, sampled on start
//  src_req_start_o   out  1       plaintext source req_start
//  src_addr_o        out  ADDR_W  current plaintext block address
//  src_ready_start_i in   1       source ready_start
//  src_done_i        in   1       source done (block delivered)
//  eng_start_o       out  1       engine start pulse (key expansion)
//  eng_enable_o      out  1       engine enable for one block
//  eng_done_i        in   1       engine block complete
//  snk_req_start_o   out  1       ciphertext sink req_start
//  snk_addr_o        out  ADDR_W  current ciphertext block address
//  snk_ready_start_i in   1       sink ready_start
//  snk_done_i        in   1       sink done (block written)
//  busy_o            out  1       high in any state except IDLE
//  done_o            out  1       one-cycle job completion pulse
//  error_o           out  1       sticky watchdog error, cleared by next accepted start
//  blocks_done_o     out  CNT_W   blocks fully stored in current/last job
// BEHAVIOUR
//  Reset/clear: state=IDLE. All outputs 0, including counters, addresses and error_o.
//  States and transitions (registered state, Moore outputs):
//   IDLE:     start_i & nb_blocks_i!=0 -> START. Latch bases and count; clear error_o and blocks_done_o.
//             start_i & nb_blocks_i==0 -> FINISH (no memory traffic).
//   START:    eng_start_o=1 for 1 cycle -> REQ_SRC.
//   REQ_SRC:  src_req_start_o=1 until src_ready_start_i=1 -> LOAD.
//   LOAD:     wait src_done_i -> WAIT_ENG. eng_enable_o=1 for 1 cycle, the cycle src_done_i is seen.
//   WAIT_ENG: wait eng_done_i -> REQ_SNK. Watchdog increments each cycle here.
//             On reaching all-ones -> ERROR.
//   REQ_SNK:  snk_req_start_o=1 until snk_ready_start_i=1 -> STORE.
//   STORE:    wait snk_done_i. Then blocks_done_o+=1, src_addr+=BLOCK_BYTES, snk_addr+=BLOCK_BYTES.
//             If blocks_done_o+1==latched count -> FINISH, else -> REQ_SRC.
//   FINISH:   done_o=1 for 1 cycle -> IDLE.
//   ERROR:    error_o set (sticky), done_o=1 for 1 cycle -> IDLE.
//  src_addr_o/snk_addr_o hold the latched base plus BLOCK_BYTES*blocks_done_o. Addresses wrap modulo 2**ADDR_W.
//  eng_start_o is issued once per job, not per block. The engine keeps its key between blocks.
//  Watchdog resets to 0 on entry to WAIT_ENG.
//  If eng_done_i arrives in the same cycle the watchdog saturates, done wins -> REQ_SNK.
//  start_i outside IDLE is ignored. Done/ready inputs in states that do not wait on them are ignored.
//  clear or reset mid-job aborts immediately: no done_o, and latched counts are discarded.
//  Minimum per-block latency with all handshakes same-cycle is 5 cycles (REQ_SRC..STORE).
//  A 1-block job takes 8 cycles from the start_i edge to the done_o cycle.
// TESTING
//  1 block: nb=1, src=0x1000, dst=0x2000, zero-delay handshakes -> src_addr 0x1000, snk_addr 0x2000.
//    One eng_start, one eng_enable, done_o 8 cycles after start, blocks_done=1.
//  4 blocks with random 0-5 cycle handshake delays -> src_addrs 0x1000/10/20/30, eng_start once.
//    eng_enable 4x, blocks_done=4, single done_o.
//  nb=0 -> done_o 2 cycles after start. No req_start or eng pulses. blocks_done=0.
//  eng_done_i never asserted -> error_o=1 and done_o pulse after 255 WAIT_ENG cycles.
//    Next start clears error_o.
//  clear asserted in WAIT_ENG of block 2 of 3 -> next cycle IDLE, all outputs 0, no done_o.
//    Restart runs a full job. Same check with async reset mid-STORE.
//  src=0xFFFF_FFF0, nb=2 -> second src_addr wraps to 0x0000_0000. start_i pulsed while busy is ignored.

Source files
------------

// File: rtl/aes_multiblock_ctrl.sv
// rtl/aes_multiblock_ctrl.sv - multi-block AES job sequencer with per-block handshakes and engine watchdog
//
// Ports:
//   clk, reset (async, active-high), clear (sync soft reset)
//   start_i, nb_blocks_i, src_base_i, dst_base_i      : job launch from register file
//   src_req_start_o, src_addr_o, src_ready_start_i,
//   src_done_i                                        : plaintext source streamer
//   eng_start_o, eng_enable_o, eng_done_i             : AES engine
//   snk_req_start_o, snk_addr_o, snk_ready_start_i,
//   snk_done_i                                        : ciphertext sink streamer
//   busy_o, done_o, error_o, blocks_done_o            : status back to register file

module aes_multiblock_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned WDOG_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  nb_blocks_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  output logic              src_req_start_o,
  output logic [ADDR_W-1:0] src_addr_o,
  input  logic              src_ready_start_i,
  input  logic              src_done_i,
  output logic              eng_start_o,
  output logic              eng_enable_o,
  input  logic              eng_done_i,
  output logic              snk_req_start_o,
  output logic [ADDR_W-1:0] snk_addr_o,
  input  logic              snk_ready_start_i,
  input  logic              snk_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [CNT_W-1:0]  blocks_done_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_REQ_SRC,
    S_LOAD,
    S_WAIT_ENG,
    S_REQ_SNK,
    S_STORE,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BLOCK_BYTES);
  // Watchdog value during the last permitted WAIT_ENG cycle: the counter
  // would reach all-ones on this edge.
  localparam logic [WDOG_W-1:0] WDOG_LAST = ~(WDOG_W'(1));

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  nb_q;
  logic [CNT_W-1:0]  blocks_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [WDOG_W-1:0] wdog_q;
  logic              error_q;

  logic wdog_trip;
  logic last_blk;

  assign wdog_trip = (wdog_q == WDOG_LAST);
  assign last_blk  = ((blocks_q + CNT_W'(1)) == nb_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (nb_blocks_i != '0) ? S_START : S_FINISH;
        end
      end
      S_START:    state_d = S_REQ_SRC;
      S_REQ_SRC:  if (src_ready_start_i) state_d = S_LOAD;
      S_LOAD:     if (src_done_i) state_d = S_WAIT_ENG;
      S_WAIT_ENG: begin
        // A completing engine beats a watchdog expiring in the same cycle.
        if (eng_done_i) begin
          state_d = S_REQ_SNK;
        end else if (wdog_trip) begin
          state_d = S_ERROR;
        end
      end
      S_REQ_SNK:  if (snk_ready_start_i) state_d = S_STORE;
      S_STORE: begin
        if (snk_done_i) begin
          state_d = last_blk ? S_FINISH : S_REQ_SRC;
        end
      end
      S_FINISH:   state_d = S_IDLE;
      S_ERROR:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      nb_q     <= '0;
      blocks_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      wdog_q   <= '0;
      error_q  <= 1'b0;
    end else if (clear) begin
      state_q  <= S_IDLE;
      nb_q     <= '0;
      blocks_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      wdog_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      // Held at zero outside WAIT_ENG so every entry starts a fresh count.
      wdog_q <= (state_q == S_WAIT_ENG) ? wdog_q + WDOG_W'(1) : '0;

      if (state_q == S_IDLE && start_i) begin
        error_q  <= 1'b0;
        blocks_q <= '0;
        if (nb_blocks_i != '0) begin
          nb_q  <= nb_blocks_i;
          src_q <= src_base_i;
          dst_q <= dst_base_i;
        end
      end

      if (state_q == S_WAIT_ENG && state_d == S_ERROR) begin
        error_q <= 1'b1;
      end

      if (state_q == S_STORE && snk_done_i) begin
        blocks_q <= blocks_q + CNT_W'(1);
        src_q    <= src_q + ADDR_STEP;
        dst_q    <= dst_q + ADDR_STEP;
      end
    end
  end

  assign eng_start_o     = (state_q == S_START);
  assign src_req_start_o = (state_q == S_REQ_SRC);
  // Enable fires in the cycle the plaintext block lands, so the engine sees
  // it together with the data.
  assign eng_enable_o    = (state_q == S_LOAD) && src_done_i;
  assign snk_req_start_o = (state_q == S_REQ_SNK);
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_FINISH) || (state_q == S_ERROR);
  assign error_o         = error_q;
  assign blocks_done_o   = blocks_q;
  assign src_addr_o      = src_q;
  assign snk_addr_o      = dst_q;

endmodule

// File: tb/tb_aes_multiblock_ctrl.sv
// tb/tb_aes_multiblock_ctrl.sv - scoreboard bench for aes_multiblock_ctrl

module tb_aes_multiblock_ctrl;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        start_i;
  logic [15:0] nb_blocks_i;
  logic [31:0] src_base_i;
  logic [31:0] dst_base_i;
  logic        src_req_start_o;
  logic [31:0] src_addr_o;
  logic        src_ready_start_i;
  logic        src_done_i;
  logic        eng_start_o;
  logic        eng_enable_o;
  logic        eng_done_i;
  logic        snk_req_start_o;
  logic [31:0] snk_addr_o;
  logic        snk_ready_start_i;
  logic        snk_done_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] blocks_done_o;

  aes_multiblock_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .clear             (clear),
    .start_i           (start_i),
    .nb_blocks_i       (nb_blocks_i),
    .src_base_i        (src_base_i),
    .dst_base_i        (dst_base_i),
    .src_req_start_o   (src_req_start_o),
    .src_addr_o        (src_addr_o),
    .src_ready_start_i (src_ready_start_i),
    .src_done_i        (src_done_i),
    .eng_start_o       (eng_start_o),
    .eng_enable_o      (eng_enable_o),
    .eng_done_i        (eng_done_i),
    .snk_req_start_o   (snk_req_start_o),
    .snk_addr_o        (snk_addr_o),
    .snk_ready_start_i (snk_ready_start_i),
    .snk_done_i        (snk_done_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .error_o           (error_o),
    .blocks_done_o     (blocks_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] all_outs();
    return {9'd0, src_req_start_o, src_addr_o, eng_start_o, eng_enable_o, snk_req_start_o,
            snk_addr_o, busy_o, done_o, error_o, blocks_done_o};
  endfunction

  typedef struct {
    int blocks;
    bit err;
  } job_t;

  logic [31:0] src_q[$];
  logic [31:0] dst_q[$];
  job_t        job_q[$];

  int fixed_dly = 0;
  int eng_fixed = -1;
  bit eng_hang  = 1'b0;

  int eng_start_cnt = 0;
  int eng_en_cnt    = 0;
  int done_cnt      = 0;
  int snk_hs_cnt    = 0;

  function automatic int dly();
    return (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 5));
  endfunction

  // Streamer/engine responders with optional random handshake latency.
  initial begin
    bit ld_ph, eng_ph, st_ph;
    int src_wait, ld_wait, eng_wait, snk_wait, st_wait;
    logic [31:0] e;
    ld_ph = 0; eng_ph = 0; st_ph = 0;
    src_wait = 0; ld_wait = 0; eng_wait = 0; snk_wait = 0; st_wait = 0;
    src_ready_start_i = 1'b0;
    src_done_i        = 1'b0;
    eng_done_i        = 1'b0;
    snk_ready_start_i = 1'b0;
    snk_done_i        = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_start_o) eng_start_cnt++;
      if (done_o) done_cnt++;
      src_ready_start_i = 1'b0;
      src_done_i        = 1'b0;
      eng_done_i        = 1'b0;
      snk_ready_start_i = 1'b0;
      snk_done_i        = 1'b0;
      if (!busy_o) begin
        ld_ph = 0; eng_ph = 0; st_ph = 0;
        src_wait = dly();
        snk_wait = dly();
      end else begin
        if (st_ph) begin
          if (st_wait == 0) begin snk_done_i = 1'b1; st_ph = 0; end
          else st_wait--;
        end
        if (eng_ph && !eng_hang) begin
          if (eng_wait == 0) begin eng_done_i = 1'b1; eng_ph = 0; end
          else eng_wait--;
        end
        if (ld_ph) begin
          if (ld_wait == 0) begin
            src_done_i = 1'b1;
            ld_ph      = 0;
            eng_ph     = 1;
            eng_wait   = (eng_fixed >= 0) ? eng_fixed : dly();
          end else ld_wait--;
        end
        if (snk_req_start_o) begin
          if (snk_wait == 0) begin
            snk_ready_start_i = 1'b1;
            snk_hs_cnt++;
            if (dst_q.size() == 0) check_eq("snk_extra_req", dst_q.size(), 1);
            else begin
              e = dst_q.pop_front();
              check_eq("snk_addr", snk_addr_o, e);
            end
            st_ph    = 1;
            st_wait  = dly();
            snk_wait = dly();
          end else snk_wait--;
        end
        if (src_req_start_o) begin
          if (src_wait == 0) begin
            src_ready_start_i = 1'b1;
            if (src_q.size() == 0) check_eq("src_extra_req", src_q.size(), 1);
            else begin
              e = src_q.pop_front();
              check_eq("src_addr", src_addr_o, e);
            end
            ld_ph    = 1;
            ld_wait  = dly();
            src_wait = dly();
          end else src_wait--;
        end
      end
      #1;
      if (eng_enable_o) eng_en_cnt++;
    end
  end

  task automatic push_addrs(input int nb, input logic [31:0] src, input logic [31:0] dst);
    logic [31:0] a, b;
    a = src;
    b = dst;
    for (int i = 0; i < nb; i++) begin
      src_q.push_back(a);
      dst_q.push_back(b);
      a = a + 32'd16;
      b = b + 32'd16;
    end
  endtask

  // Launches a job, waits for done_o and scores it. lat counts cycles from
  // the cycle start_i is high through the done_o cycle, both inclusive.
  task automatic run_job(input int nb, input logic [31:0] src, input logic [31:0] dst,
                         input int exp_blocks, input bit exp_err, input bit poke,
                         output int lat);
    int s0, e0, d0;
    bit seen;
    job_t j;
    job_t got;
    push_addrs(nb, src, dst);
    j.blocks = exp_blocks;
    j.err    = exp_err;
    job_q.push_back(j);
    s0 = eng_start_cnt; e0 = eng_en_cnt; d0 = done_cnt;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    start_i     = 1'b1;
    nb_blocks_i = 16'(nb);
    src_base_i  = src;
    dst_base_i  = dst;
    @(negedge clk);
    start_i     = 1'b0;
    nb_blocks_i = 16'($urandom);
    src_base_i  = $urandom;
    dst_base_i  = $urandom;
    check_eq("busy_after_start", busy_o, 1);
    check_eq("err_cleared_on_start", error_o, 0);
    for (int n = 1; n <= 2000; n++) begin
      #3;
      if (poke && n == 4) begin
        start_i     = 1'b1;
        nb_blocks_i = 16'd7;
        src_base_i  = 32'hDEAD_0000;
      end else if (poke && n == 5) begin
        start_i = 1'b0;
      end
      if (done_o) begin
        lat  = n + 1;
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    check_eq("done_seen", seen, 1);
    if (seen) begin
      got = job_q.pop_front();
      check_eq("blocks_done", blocks_done_o, got.blocks);
      check_eq("error_at_done", error_o, got.err);
    end
    repeat (3) @(negedge clk);
    #3;
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("eng_start_pulses", eng_start_cnt - s0, (nb != 0) ? 1 : 0);
    check_eq("eng_enable_pulses", eng_en_cnt - e0, nb);
    check_eq("src_left", src_q.size(), 0);
    check_eq("dst_left", dst_q.size(), exp_err ? 1 : 0);
    check_eq("idle_after_job", busy_o, 0);
    src_q.delete();
    dst_q.delete();
    job_q.delete();
  endtask

  initial begin
    int lat;
    int e0, d0, h0;
    bit hit;
    reset       = 1'b1;
    clear       = 1'b0;
    start_i     = 1'b0;
    nb_blocks_i = '0;
    src_base_i  = '0;
    dst_base_i  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    check_eq("reset_state", all_outs(), 96'd0);

    // Single block, zero-delay handshakes.
    fixed_dly = 0;
    run_job(1, 32'h1000, 32'h2000, 1, 1'b0, 1'b0, lat);
    check_eq("lat_1blk", lat, 8);
    check_eq("src_addr_after_1blk", src_addr_o, 32'h1010);

    // Four blocks with random handshake delays.
    fixed_dly = -1;
    run_job(4, 32'h1000, 32'h2000, 4, 1'b0, 1'b0, lat);

    // Empty job.
    fixed_dly = 0;
    run_job(0, 32'h3000, 32'h4000, 0, 1'b0, 1'b0, lat);
    check_eq("lat_nb0", lat, 2);

    // Engine never finishes: 3 setup cycles, 255 watchdog cycles, ERROR.
    eng_hang = 1'b1;
    run_job(1, 32'h5000, 32'h6000, 0, 1'b1, 1'b0, lat);
    eng_hang = 1'b0;
    check_eq("lat_wdog", lat, 260);
    check_eq("err_sticky", error_o, 1);

    // Next accepted start clears the error.
    fixed_dly = -1;
    run_job(2, 32'h7000, 32'h9000, 2, 1'b0, 1'b0, lat);

    // Engine done lands in the watchdog's final cycle: completion wins.
    fixed_dly = 0;
    eng_fixed = 254;
    run_job(1, 32'hA000, 32'hB000, 1, 1'b0, 1'b0, lat);
    check_eq("lat_done_wins", lat, 262);
    eng_fixed = -1;

    // Soft clear during WAIT_ENG of block 2 of 3.
    fixed_dly = 0;
    eng_fixed = 3;
    push_addrs(3, 32'hC000, 32'hD000);
    e0 = eng_en_cnt; d0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1; nb_blocks_i = 16'd3; src_base_i = 32'hC000; dst_base_i = 32'hD000;
    @(negedge clk);
    start_i = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 200; n++) begin
      #3;
      if (eng_en_cnt - e0 == 2) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("clear_reached_blk2", hit, 1);
    @(negedge clk);
    #3;
    clear = 1'b1;
    @(negedge clk);
    #3;
    clear = 1'b0;
    check_eq("after_clear_outs", all_outs(), 96'd0);
    repeat (3) @(negedge clk);
    #3;
    check_eq("clear_no_done", done_cnt - d0, 0);
    src_q.delete();
    dst_q.delete();
    eng_fixed = -1;
    fixed_dly = -1;
    run_job(3, 32'hC000, 32'hD000, 3, 1'b0, 1'b0, lat);

    // Async reset during STORE of block 2 of 2.
    fixed_dly = 3;
    push_addrs(2, 32'hE000, 32'hF000);
    h0 = snk_hs_cnt; d0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1; nb_blocks_i = 16'd2; src_base_i = 32'hE000; dst_base_i = 32'hF000;
    @(negedge clk);
    start_i = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 300; n++) begin
      #3;
      if (snk_hs_cnt - h0 == 2) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("reset_reached_store2", hit, 1);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_reset_outs", all_outs(), 96'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check_eq("reset_no_done", done_cnt - d0, 0);
    src_q.delete();
    dst_q.delete();
    fixed_dly = -1;
    run_job(2, 32'hE000, 32'hF000, 2, 1'b0, 1'b0, lat);

    // Address wrap, with a stray start pulse mid-job.
    run_job(2, 32'hFFFF_FFF0, 32'h0000_8000, 2, 1'b0, 1'b1, lat);
    check_eq("src_addr_wrapped", src_addr_o, 32'h0000_0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
